video_line_fetcher: RTL
=======================

// Module: video_line_fetcher
// PURPOSE
//  Initiator on the video port of the SDRAM arbiter (video_sdram_rd/rdy/ack/addr/rdata).
//  Streams a linear 16-bpp framebuffer from SDRAM in fixed-length bursts into a show-ahead FIFO.
//  The pixel pipeline pops words from that FIFO at its own pace.
//  Sits between the arbiter's video client port and the scanout/pixel generator.
// PARAMETERS
//  BURST_LEN    8      words per SDRAM request; power of 2, >=2; must divide FRAME_WORDS
//  FIFO_DEPTH   64     FIFO entries (16-bit); power of 2, >= 2*BURST_LEN
//  FRAME_WORDS  76800  words per frame (320x240x16bpp)
// PORTS
//  clk_i                 in   1   system clock
//  rst_i                 in   1   synchronous reset, active-high
//  frame_start_i         in   1   pulse: flush FIFO, restart fetch at fb_base_x16_i
//  fb_base_x16_i         in   24  framebuffer base, 16-bit word address; sampled on frame_start_i
//  video_sdram_rd        out  1   read request; held high for the whole burst
//  video_sdram_addr_x16  out  24  burst start address; stable while rd=1
//  video_sdram_rdy       in   1   one 16-bit word valid on video_sdram_rdata this cycle
//  video_sdram_rdata     in   16  read data
//  video_sdram_ack       out  1   1-cycle pulse that closes the burst
//  pix_valid_o           out  1   FIFO not empty
//  pix_data_o            out  16  FIFO head word (show-ahead)
//  pix_rd_i              in   1   pop FIFO head
//  underrun_o            out  1   sticky: pop attempted while empty; cleared by frame_start_i
// BEHAVIOUR
//  Reset: rd=0, ack=0, addr=0, pix_valid_o=0, underrun_o=0, FIFO empty, state IDLE, done=1.
//  Fetch stays idle until the first frame_start_i.
//  FSM IDLE -> REQ -> ACK -> IDLE.
//  - IDLE: go to REQ next cycle when done=0 and FIFO free >= BURST_LEN.
//    Free count = FIFO_DEPTH - occupancy, registered.
//  - REQ: rd=1, addr=fetch_ptr. Every rdy cycle writes rdata into the FIFO and increments word_cnt.
//    Entering ACK happens on the rdy that delivers word BURST_LEN-1.
//  - ACK: rd=0, ack=1 for exactly one cycle. Then fetch_ptr += BURST_LEN, frame_cnt += BURST_LEN.
//    done=1 when frame_cnt reaches FRAME_WORDS. Then IDLE.
//  - Minimum gap between bursts: one IDLE cycle.
//  Arbiter wait states are absorbed: rd stays high with no timeout until all BURST_LEN rdy pulses arrive.
//  rdy seen outside REQ is ignored.
//  FIFO timing:
//  - Word written on a rdy edge appears at pix_data_o (pix_valid_o=1) on the next cycle.
//  - Simultaneous write and pop are both honoured; occupancy is unchanged.
//  - Pop while empty: no pointer change; underrun_o<=1; pix_data_o undefined.
//  Overflow cannot occur: a burst is issued only with BURST_LEN free entries and the pixel side only pops.
//  Address is 24-bit and wraps modulo 2^24.
//  frame_start_i in IDLE/ACK:
//  - FIFO flushed, fetch_ptr<=fb_base_x16_i, frame_cnt<=0, done<=0, underrun_o<=0.
//  - If in ACK, the ACK is still completed; its pointer update is suppressed.
//  frame_start_i in REQ:
//  - Burst runs to completion; the protocol cannot be aborted.
//  - Its remaining words are discarded (not written).
//  - Pointers are reloaded as above; the ACK is still issued.
//  - FIFO flushed on the frame_start_i cycle.
//  frame_start_i coincident with a pop: the flush wins.
//  rst_i mid-burst: all state returns to reset values next cycle. The arbiter shares rst_i, so no ack is owed.
// CONFIGURATION
//  VIDEO_FETCH_STATS_EN defined:
//  - Adds output underrun_count_o[15:0]: counts pops-while-empty, saturating at 16'hFFFF.
//  - Cleared by rst_i and frame_start_i.
//  - Adds output burst_count_o[15:0]: counts completed ACK cycles, wraps, cleared by rst_i only.
//  Undefined: both ports and both counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package poly94_video_pkg: fetch_state_t enum {FS_IDLE, FS_REQ, FS_ACK}, ADDR_W=24, PIX_W=16.
//  Sub-module video_fifo:
//  - Synchronous show-ahead FIFO: wr_en, wr_data, rd_en, flush, rd_data, empty, count.
//  - Parameterised by DEPTH and WIDTH.
//  The FSM, pointers and counters live in video_line_fetcher.
// TESTING
//  1 Reset, frame_start_i with base=24'h010000, arbiter model returns rdy 2 cycles after rd.
//    -> rd=1, addr=24'h010000; 8 FIFO writes; ack pulse for 1 cycle; next burst addr=24'h010008.
//  2 No pops, FIFO_DEPTH=64 -> exactly 8 bursts issued, then rd stays 0.
//    One pop -> still no request (free=1 < 8); 8 pops -> next burst starts.
//  3 Pop every cycle from empty -> underrun_o=1 sticky.
//    With STATS_EN: underrun_count_o increments per empty pop; frame_start_i clears both.
//  4 frame_start_i on word 3 of a burst, new base=24'h020000.
//    -> burst still delivers 8 rdy and is acked; FIFO empty afterwards; next addr=24'h020000.
//  5 FRAME_WORDS=32 with continuous pops -> exactly 4 bursts, then idle.
//    frame_start_i resumes fetching from base.
//  6 rdy with 0-3 random wait cycles between words and random pop pattern.
//    -> popped sequence equals SDRAM model contents in address order; no overflow; ack once per burst.

Source files
------------

// File: rtl/video_line_fetcher_pkg.sv
// Shared types and widths for the video fetch path: FSM encoding and bus widths
// used by video_line_fetcher and its FIFO.
package poly94_video_pkg;

  localparam int ADDR_W = 24;
  localparam int PIX_W  = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_ACK
  } fetch_state_t;

endpackage

// File: rtl/video_line_fetcher_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rd_data whenever
// empty is low; flush empties it in one cycle and dominates write and pop.
module video_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_do_wr;
  logic w_do_rd;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_do_wr = wr_en && !flush && !w_full;
  assign w_do_rd = rd_en && !flush && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage carries no reset; validity is tracked by the pointers, and an
  // unreset array maps onto plain RAM instead of a flop bank with reset muxes.
  always_ff @(posedge clk_i) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

// File: rtl/video_line_fetcher.sv
// Burst fetcher from SDRAM arbiter video port into a show-ahead pixel FIFO.
// Optional VIDEO_FETCH_STATS_EN adds underrun_count_o and burst_count_o.
module video_line_fetcher
  import poly94_video_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 64,
  parameter int FRAME_WORDS = 76800
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic [ADDR_W-1:0] fb_base_x16_i,
  output logic              video_sdram_rd,
  output logic [ADDR_W-1:0] video_sdram_addr_x16,
  input  logic              video_sdram_rdy,
  input  logic [PIX_W-1:0]  video_sdram_rdata,
  output logic              video_sdram_ack,
  output logic              pix_valid_o,
  output logic [PIX_W-1:0]  pix_data_o,
  input  logic              pix_rd_i,
  output logic              underrun_o
`ifdef VIDEO_FETCH_STATS_EN
  ,
  output logic [15:0]       underrun_count_o,
  output logic [15:0]       burst_count_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = $clog2(BURST_LEN);
  localparam int FW    = $clog2(FRAME_WORDS + 1);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_fetch_ptr;
  logic [ADDR_W-1:0] r_burst_addr;
  logic [FW-1:0]     r_frame_cnt;
  logic              r_done;
  logic [BW-1:0]     r_word_cnt;
  logic              r_discard;
  logic [CNT_W-1:0]  r_free;
  logic              r_underrun;

  logic              w_fifo_wr;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_last_word;
  logic              w_pop_empty;

  assign w_last_word = (r_state == FS_REQ) && video_sdram_rdy &&
                       (r_word_cnt == BW'(BURST_LEN - 1));
  assign w_fifo_wr   = (r_state == FS_REQ) && video_sdram_rdy && !r_discard;
  assign w_pop_empty = pix_rd_i && w_fifo_empty;

  video_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (w_fifo_wr),
    .wr_data (video_sdram_rdata),
    .rd_en   (pix_rd_i),
    .flush   (frame_start_i),
    .rd_data (pix_data_o),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FS_IDLE;
    else       r_state <= w_next_state;
  end

  // A frame start in IDLE holds off the request so the burst address comes from
  // the freshly loaded base rather than the stale pointer.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned (latch).
    w_next_state = r_state;
    case (r_state)
      FS_IDLE: if (!r_done && !frame_start_i && (r_free >= CNT_W'(BURST_LEN)))
                 w_next_state = FS_REQ;
      FS_REQ:  if (w_last_word) w_next_state = FS_ACK;
      FS_ACK:  w_next_state = FS_IDLE;
      default: w_next_state = FS_IDLE;
    endcase
  end

  always_comb begin
    video_sdram_rd  = (r_state == FS_REQ);
    video_sdram_ack = (r_state == FS_ACK);
  end

  assign video_sdram_addr_x16 = r_burst_addr;
  assign pix_valid_o          = !w_fifo_empty;
  assign underrun_o           = r_underrun;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_ptr  <= '0;
      r_burst_addr <= '0;
      r_frame_cnt  <= '0;
      r_done       <= 1'b1;
      r_word_cnt   <= '0;
      r_discard    <= 1'b0;
      r_free       <= CNT_W'(FIFO_DEPTH);
      r_underrun   <= 1'b0;
    end else begin
      r_free <= CNT_W'(FIFO_DEPTH) - w_fifo_count;

      if (r_state == FS_IDLE && w_next_state == FS_REQ) r_burst_addr <= r_fetch_ptr;
      if (r_state == FS_REQ && video_sdram_rdy)         r_word_cnt   <= r_word_cnt + 1'b1;

      // A restart during the burst or its ACK owns the pointers; the burst's own
      // advance is dropped.
      if (frame_start_i) begin
        r_fetch_ptr <= fb_base_x16_i;
        r_frame_cnt <= '0;
        r_done      <= 1'b0;
      end else if (r_state == FS_ACK && !r_discard) begin
        r_fetch_ptr <= r_fetch_ptr + ADDR_W'(BURST_LEN);
        r_frame_cnt <= r_frame_cnt + FW'(BURST_LEN);
        if (r_frame_cnt + FW'(BURST_LEN) == FW'(FRAME_WORDS)) r_done <= 1'b1;
      end

      if (r_state == FS_ACK)                         r_discard <= 1'b0;
      else if (frame_start_i && r_state == FS_REQ)   r_discard <= 1'b1;

      if (frame_start_i)    r_underrun <= 1'b0;
      else if (w_pop_empty) r_underrun <= 1'b1;
    end
  end

`ifdef VIDEO_FETCH_STATS_EN
  logic [15:0] r_underrun_count;
  logic [15:0] r_burst_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_underrun_count <= '0;
      r_burst_count    <= '0;
    end else begin
      if (frame_start_i)
        r_underrun_count <= '0;
      else if (w_pop_empty && r_underrun_count != 16'hFFFF)
        r_underrun_count <= r_underrun_count + 1'b1;
      if (r_state == FS_ACK) r_burst_count <= r_burst_count + 1'b1;
    end
  end

  assign underrun_count_o = r_underrun_count;
  assign burst_count_o    = r_burst_count;
`endif

endmodule
